// File: rtl/alu_share_ctrl.sv
// Shares one external combinational 74181-style ALU between two requesters.
// Round-robin grant in IDLE, one ALU evaluation cycle in EXEC, response held in RESP.
module alu_share_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_m,
  input  logic [3:0]       req0_s,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_m,
  input  logic [3:0]       req1_s,
  input  logic             req1_cin,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_m,
  output logic [3:0]       alu_s,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_f,
  input  logic             alu_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_f,
  output logic             rsp_cout,
  output logic             rsp_zero,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic             last_q;
  logic             id_q;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic             alu_m_q, alu_m_d;
  logic [3:0]       alu_s_q, alu_s_d;
  logic             alu_cin_q, alu_cin_d;
  logic [WIDTH-1:0] rsp_f_q;
  logic             rsp_cout_q;
  logic             rsp_valid_q;

  logic gnt_id;
  logic accept;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    gnt_id = req1_valid;
    if (req0_valid && req1_valid) begin
      gnt_id = ~last_q;
    end
    accept     = (state_q == IDLE) && !rst && (req0_valid || req1_valid);
    req0_ready = accept && !gnt_id;
    req1_ready = accept && gnt_id;
  end

  always_comb begin
    alu_a_d   = req0_a;
    alu_b_d   = req0_b;
    alu_m_d   = req0_m;
    alu_s_d   = req0_s;
    alu_cin_d = req0_cin;
    if (gnt_id) begin
      alu_a_d   = req1_a;
      alu_b_d   = req1_b;
      alu_m_d   = req1_m;
      alu_s_d   = req1_s;
      alu_cin_d = req1_cin;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      id_q        <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_m_q     <= 1'b0;
      alu_s_q     <= '0;
      alu_cin_q   <= 1'b0;
      rsp_f_q     <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // ALU inputs only move on acceptance, so they keep the last op afterwards.
      if (accept) begin
        alu_a_q   <= alu_a_d;
        alu_b_q   <= alu_b_d;
        alu_m_q   <= alu_m_d;
        alu_s_q   <= alu_s_d;
        alu_cin_q <= alu_cin_d;
        id_q      <= gnt_id;
        last_q    <= gnt_id;
      end
      if (state_q == EXEC) begin
        rsp_f_q     <= alu_f;
        rsp_cout_q  <= alu_cout;
        rsp_valid_q <= 1'b1;
      end
      if (state_q == RESP && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_m     = alu_m_q;
  assign alu_s     = alu_s_q;
  assign alu_cin   = alu_cin_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_f     = rsp_f_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_zero  = (rsp_f_q == '0);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with an adder standing in for the shared ALU.
module tb_alu_share_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_m, req0_cin;
  logic [15:0] req0_a, req0_b;
  logic [3:0]  req0_s;
  logic        req1_valid, req1_ready, req1_m, req1_cin;
  logic [15:0] req1_a, req1_b;
  logic [3:0]  req1_s;
  logic [15:0] alu_a, alu_b, alu_f;
  logic        alu_m, alu_cin, alu_cout;
  logic [3:0]  alu_s;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_zero, busy;
  logic [15:0] rsp_f;
  logic [16:0] alu_sum;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Stand-in ALU: F = A + B + cin regardless of M/S.
  assign alu_sum  = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_cin};
  assign alu_f    = alu_sum[15:0];
  assign alu_cout = alu_sum[16];

  alu_share_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_m(req0_m), .req0_s(req0_s), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_m(req1_m), .req1_s(req1_s), .req1_cin(req1_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_m(alu_m), .alu_s(alu_s), .alu_cin(alu_cin),
    .alu_f(alu_f), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_f(rsp_f),
    .rsp_cout(rsp_cout), .rsp_zero(rsp_zero), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".rsp_id"},    32'(rsp_id),    32'd0);
    chk({tag, ".rsp_f"},     32'(rsp_f),     32'd0);
    chk({tag, ".rsp_cout"},  32'(rsp_cout),  32'd0);
    chk({tag, ".rsp_zero"},  32'(rsp_zero),  32'd1);
    chk({tag, ".alu_ops"},   {alu_a, alu_b}, 32'd0);
    chk({tag, ".alu_ctl"},   32'({alu_m, alu_s, alu_cin}), 32'd0);
    chk({tag, ".busy"},      32'(busy),      32'd0);
  endtask

  // One operation from requester id, rsp_ready assumed high; checks exact latency.
  task automatic run_op(input logic id, input logic [15:0] a, input logic [15:0] b,
                        input logic m, input logic [3:0] s, input logic cin,
                        input logic [15:0] ef, input logic ec);
    int n = 0;
    if (id) begin
      req1_a = a; req1_b = b; req1_m = m; req1_s = s; req1_cin = cin; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_m = m; req0_s = s; req0_cin = cin; req0_valid = 1'b1;
    end
    @(negedge clk);
    while (!(id ? req1_ready : req0_ready) && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("op.grant", 32'(id ? req1_ready : req0_ready), 32'd1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    chk("op.alu_ops", {alu_a, alu_b}, {a, b});
    chk("op.alu_ctl", 32'({alu_m, alu_s, alu_cin}), 32'({m, s, cin}));
    chk("op.exec_busy", 32'(busy), 32'd1);
    chk("op.exec_nvalid", 32'(rsp_valid), 32'd0);
    step();
    @(negedge clk);
    chk("op.rsp_valid", 32'(rsp_valid), 32'd1);
    chk("op.rsp", 32'({rsp_id, rsp_cout, rsp_zero, rsp_f}), 32'({id, ec, ef == 16'd0, ef}));
    $display("op id=%0d a=%04h b=%04h cin=%0d -> f=%04h cout=%0d zero=%0d", id, a, b, cin, rsp_f, rsp_cout, rsp_zero);
    step();
    chk("op.rsp_done", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_m = 1'b0; req0_s = '0; req0_cin = 1'b0;
    req1_valid = 1'b1; req1_a = '0; req1_b = '0; req1_m = 1'b0; req1_s = '0; req1_cin = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("rst.ready", 32'({req1_ready, req0_ready}), 32'd0);
    chk_reset_outputs("rst");
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    rst = 1'b0;

    // Single request and carry/zero.
    run_op(1'b0, 16'h1234, 16'h0001, 1'b0, 4'h9, 1'b0, 16'h1235, 1'b0);
    run_op(1'b1, 16'hFFFF, 16'h0001, 1'b1, 4'h6, 1'b0, 16'h0000, 1'b1);

    // Contention: last winner was 1, so the order is 0,1,0,1.
    req0_a = 16'h1000; req0_b = 16'h0234; req0_m = 1'b0; req0_s = 4'h3; req0_cin = 1'b1;
    req1_a = 16'h8000; req1_b = 16'h8001; req1_m = 1'b1; req1_s = 4'hC; req1_cin = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic w;
      w = k[0];
      @(negedge clk);
      chk("cont.ready", 32'({req1_ready, req0_ready}), w ? 32'd2 : 32'd1);
      step();
      @(negedge clk);
      chk("cont.alu_ops", {alu_a, alu_b}, w ? {16'h8000, 16'h8001} : {16'h1000, 16'h0234});
      chk("cont.alu_ctl", 32'({alu_m, alu_s, alu_cin}), w ? 32'b1_1100_0 : 32'b0_0011_1);
      step();
      @(negedge clk);
      chk("cont.rsp", 32'({rsp_valid, rsp_id, rsp_cout, rsp_f}),
          w ? 32'({1'b1, 1'b1, 1'b1, 16'h0001}) : 32'({1'b1, 1'b0, 1'b0, 16'h1235}));
      $display("contention op %0d: winner=%0d f=%04h", k, rsp_id, rsp_f);
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Backpressure: five stalled edges in RESP with req1 pending.
    rsp_ready = 1'b0;
    req0_a = 16'h00F0; req0_b = 16'h000F; req0_cin = 1'b1; req0_valid = 1'b1;
    @(negedge clk);
    chk("bp.grant", 32'(req0_ready), 32'd1);
    step();
    req0_valid = 1'b0;
    req1_a = 16'h0002; req1_b = 16'h0003; req1_cin = 1'b0; req1_valid = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp.hold", 32'({rsp_valid, rsp_id, busy, req1_ready, req0_ready, rsp_f}),
          32'({1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0100}));
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp.still_valid", 32'(rsp_valid), 32'd1);
    step();
    chk("bp.released", 32'(rsp_valid), 32'd0);
    $display("backpressure op: f=0100 released after 5 stalled cycles");
    run_op(1'b1, 16'h0002, 16'h0003, 1'b0, 4'h9, 1'b0, 16'h0005, 1'b0);

    // Reset during EXEC.
    req0_a = 16'hABCD; req0_b = 16'h1111; req0_valid = 1'b1;
    @(negedge clk);
    chk("rmid.grant", 32'(req0_ready), 32'd1);
    step();
    req0_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rmid.ready_in_rst", 32'({req1_ready, req0_ready}), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("rmid");
    step();
    @(negedge clk);
    chk("rmid.no_rsp", 32'({rsp_valid, busy}), 32'd0);
    $display("reset mid-op: in-flight op discarded");
    run_op(1'b0, 16'h4000, 16'h0001, 1'b0, 4'h9, 1'b1, 16'h4002, 1'b0);

    // Withdrawn request: req1 valid only while the block is busy with req0.
    req0_a = 16'h0001; req0_b = 16'h0001; req0_cin = 1'b0; req0_valid = 1'b1;
    @(negedge clk);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    @(negedge clk);
    chk("wd.busy_ready", 32'(req1_ready), 32'd0);
    step();
    req1_valid = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wd.idle", 32'({busy, req1_ready, rsp_valid}), 32'd0);
      step();
    end
    chk("wd.last_op", {alu_a, alu_b}, {16'h0001, 16'h0001});
    $display("withdrawn request: no grant");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Arbitrates a single shared 16-bit 74181-style ALU between two requesters and sequences each operation through it. Each requester submits an operation {A, B, M, S, cin} over a valid/ready handshake; the block grants round-robin, holds the operands steady on the ALU inputs for one evaluation cycle, registers F/cout, and returns the result with the requester ID over a valid/ready response channel. The ALU is external and combinational; this block drives its operand/control inputs and samples its outputs.

## Interface
- WIDTH, 16, operand/result width; must match the attached ALU.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  in  WIDTH  operands.
- req0_m  in  1  mode (1 = logic, 0 = arithmetic).
- req0_s  in  4  function select.
- req0_cin  in  1  carry in.
- req1_valid, req1_ready, req1_a, req1_b, req1_m, req1_s, req1_cin: same as requester 0.
- alu_a, alu_b  out  WIDTH  operands to the ALU.
- alu_m  out  1, alu_s  out  4, alu_cin  out  1: ALU controls.
- alu_f  in  WIDTH  ALU result.
- alu_cout  in  1  ALU carry out.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  1  requester that issued the result.
- rsp_f  out  WIDTH  registered result.
- rsp_cout  out  1  registered carry out.
- rsp_zero  out  1  1 when rsp_f == 0.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any reqN_valid, grant per round-robin pointer `last`; the requester not equal to `last` has priority when both are valid. If only one is valid, it wins regardless of `last`. reqN_ready is high combinationally for the granted requester only, and only in IDLE. On the edge where the transfer occurs: latch operands/controls into the op register, latch the ID, set `last` to the ID, and go to EXEC.
- EXEC: the op register drives alu_* (registered outputs, stable the whole cycle). At the end-of-cycle edge: capture alu_f into rsp_f and alu_cout into rsp_cout, set rsp_valid, and go to RESP.
- RESP: hold rsp_* and rsp_valid until rsp_valid & rsp_ready at an edge. Then clear rsp_valid and go to IDLE. No new request is accepted in RESP.
- alu_* outputs keep the last issued operation after completion; they change only on acceptance.
- rsp_zero is derived combinationally from rsp_f.
- No arithmetic inside the block. Widths pass through unchanged; cout is the ALU's carry, not recomputed.

## Timing
- Reset values: state IDLE, `last` = 1 (requester 0 wins the first tie), rsp_valid 0, rsp_id 0, rsp_f 0, rsp_cout 0, rsp_zero 1, alu_a/alu_b/alu_s 0, alu_m 0, alu_cin 0, busy 0. reqN_ready is 0 while rst is high.
- Latency: acceptance at edge k, rsp_valid high from edge k+1, earliest rsp handshake at edge k+2, next acceptance at edge k+3. Peak throughput is one operation per 3 cycles.
- A requester must hold its fields stable while valid and not ready. A dropped valid before ready is legal and causes no grant.
- Both valid in IDLE: exactly one reqN_ready is high; the loser stays pending and wins the next IDLE cycle if still valid.
- rsp_ready high while rsp_valid is low has no effect. rsp_ready held low stalls indefinitely in RESP with rsp_* stable.
- rst asserted in EXEC or RESP: the in-flight operation is discarded with no response, and all outputs take their reset values at that edge.

## Test plan
- Bench ALU model is F = A + B + cin, truncated to 16 bits with cout as the carry, regardless of M/S. Single request: req0 {A=0x1234, B=0x0001, cin=0} → req0_ready in the first IDLE cycle, rsp_valid two edges later with rsp_f=0x1235, rsp_cout=0, rsp_id=0, rsp_zero=0.
- Carry/zero: req1 {A=0xFFFF, B=0x0001, cin=0} → rsp_f=0x0000, rsp_cout=1, rsp_zero=1, rsp_id=1.
- Contention: both valid continuously after reset → grant order 0,1,0,1, each accepted op's alu_* matching the winner's fields, and rsp_id alternating.
- Backpressure: rsp_ready low for 5 cycles → rsp_f/rsp_id stable, req ready low throughout, busy=1; the response completes one edge after rsp_ready rises.
- Reset mid-op: rst pulsed one cycle while in EXEC → no rsp_valid, all outputs at reset values, and the next req0 is accepted normally.
- Withdrawn request: req1_valid pulsed for 0 cycles at ready (dropped before IDLE) → no grant, and busy stays 0.
